// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Word-aligns one deserialized TMDS channel and decodes every aligned
//   symbol as video, control, TERC4 and guard band in parallel. Alignment
//   is found by hunting for a run of control tokens, stepping the bit
//   offset whenever the search timer expires.
//
// Parameters
//   CHANNEL        TMDS channel index 0..2 (selects the guard-band pattern)
//   LOCK_COUNT     consecutive control tokens at one offset needed for lock
//   SEARCH_TIMEOUT clocks without a completed control run before the offset
//                  advances (SEARCH) or lock is dropped (LOCKED)
//
// Ports
//   clk_pixel     pixel clock, rising edge
//   RST           asynchronous active-low reset
//   raw_symbol    10-bit deserialized word, bit 0 earliest on the wire
//   locked        word alignment established
//   offset        current alignment offset 0..9
//   video_data    registered TMDS video decode of the aligned symbol
//   control_data  registered control-token decode, is_control its match flag
//   terc4_data    registered TERC4 decode, is_terc4 its match flag
//   is_guard      registered video guard-band match for this channel
module tmds_channel_decoder #(
  parameter int CHANNEL        = 0,
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048
) (
  input  logic       clk_pixel,
  input  logic       RST,
  input  logic [9:0] raw_symbol,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] video_data,
  output logic [1:0] control_data,
  output logic       is_control,
  output logic [3:0] terc4_data,
  output logic       is_terc4,
  output logic       is_guard
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SEARCH_TIMEOUT);
  localparam logic [9:0] GUARD = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
  logic [TMR_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [3:0]       r_offset, w_offset_nxt, w_offset_adv;
  logic [9:0]       r_raw_prev;
  logic [19:0]      w_window;
  logic [9:0]       w_aligned;
  logic             w_run_done, w_timeout;

  logic [7:0] w_video;
  logic [1:0] w_ctrl;
  logic       w_is_ctrl;
  logic [3:0] w_terc;
  logic       w_is_terc;

  logic [7:0] r_video;
  logic [1:0] r_ctrl;
  logic       r_is_ctrl;
  logic [3:0] r_terc;
  logic       r_is_terc;
  logic       r_is_guard;

  // ---------------- alignment window ----------------
  assign w_window = {raw_symbol, r_raw_prev};

  always_comb begin
    w_aligned = w_window[9:0];
    case (r_offset)
      4'd0: w_aligned = w_window[9:0];
      4'd1: w_aligned = w_window[10:1];
      4'd2: w_aligned = w_window[11:2];
      4'd3: w_aligned = w_window[12:3];
      4'd4: w_aligned = w_window[13:4];
      4'd5: w_aligned = w_window[14:5];
      4'd6: w_aligned = w_window[15:6];
      4'd7: w_aligned = w_window[16:7];
      4'd8: w_aligned = w_window[17:8];
      4'd9: w_aligned = w_window[18:9];
      default: w_aligned = w_window[9:0];
    endcase
  end

  // ---------------- symbol decoders ----------------
  always_comb begin
    logic [7:0] d;
    d = w_aligned[9] ? ~w_aligned[7:0] : w_aligned[7:0];
    w_video    = '0;
    w_video[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      w_video[i] = w_aligned[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  always_comb begin
    w_ctrl    = '0;
    w_is_ctrl = 1'b1;
    case (w_aligned)
      10'b1101010100: w_ctrl = 2'b00;
      10'b0010101011: w_ctrl = 2'b01;
      10'b0101010100: w_ctrl = 2'b10;
      10'b1010101011: w_ctrl = 2'b11;
      default:        w_is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    w_terc    = '0;
    w_is_terc = 1'b1;
    case (w_aligned)
      10'b1010011100: w_terc = 4'h0;
      10'b1001100011: w_terc = 4'h1;
      10'b1011100100: w_terc = 4'h2;
      10'b1011100010: w_terc = 4'h3;
      10'b0101110001: w_terc = 4'h4;
      10'b0100011110: w_terc = 4'h5;
      10'b0110001110: w_terc = 4'h6;
      10'b0100111100: w_terc = 4'h7;
      10'b1011001100: w_terc = 4'h8;
      10'b0100111001: w_terc = 4'h9;
      10'b0110011100: w_terc = 4'hA;
      10'b1011000110: w_terc = 4'hB;
      10'b1010001110: w_terc = 4'hC;
      10'b1001110001: w_terc = 4'hD;
      10'b0101100011: w_terc = 4'hE;
      10'b1011000011: w_terc = 4'hF;
      default:        w_is_terc = 1'b0;
    endcase
  end

  // ---------------- alignment FSM ----------------
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      r_state    <= S_SEARCH;
      r_run      <= '0;
      r_timer    <= '0;
      r_offset   <= '0;
      r_raw_prev <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_timer    <= w_timer_nxt;
      r_offset   <= w_offset_nxt;
      r_raw_prev <= raw_symbol;
    end
  end

  // Both counters saturate; a run completing in the same cycle the timer
  // expires takes priority, so a late but valid run is never discarded.
  assign w_run_inc    = !w_is_ctrl ? '0 : ((r_run >= RUN_MAX) ? r_run : r_run + 1'b1);
  assign w_run_done   = w_is_ctrl && (w_run_inc >= RUN_MAX);
  assign w_timer_inc  = (r_timer >= TMR_MAX) ? r_timer : r_timer + 1'b1;
  assign w_timeout    = (w_timer_inc >= TMR_MAX);
  assign w_offset_adv = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = w_run_inc;
    w_timer_nxt  = w_timer_inc;
    w_offset_nxt = r_offset;
    if (w_run_done) begin
      w_state_nxt = S_LOCKED;
      w_run_nxt   = '0;
      w_timer_nxt = '0;
    end else if (w_timeout) begin
      w_state_nxt  = S_SEARCH;
      w_run_nxt    = '0;
      w_timer_nxt  = '0;
      w_offset_nxt = w_offset_adv;
    end
  end

  always_comb begin
    locked = (r_state == S_LOCKED);
    offset = r_offset;
  end

  // ---------------- registered decode outputs ----------------
  always_ff @(posedge clk_pixel or negedge RST) begin
    if (!RST) begin
      r_video    <= '0;
      r_ctrl     <= '0;
      r_is_ctrl  <= 1'b0;
      r_terc     <= '0;
      r_is_terc  <= 1'b0;
      r_is_guard <= 1'b0;
    end else begin
      r_video    <= w_video;
      r_ctrl     <= w_ctrl;
      r_is_ctrl  <= w_is_ctrl;
      r_terc     <= w_terc;
      r_is_terc  <= w_is_terc;
      r_is_guard <= (w_aligned == GUARD);
    end
  end

  assign video_data   = r_video;
  assign control_data = r_ctrl;
  assign is_control   = r_is_ctrl;
  assign terc4_data   = r_terc;
  assign is_terc4     = r_is_terc;
  assign is_guard     = r_is_guard;

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter CHANNEL, default 0, meaning TMDS channel index 0..2; it selects the guard-band pattern to match.
REQ-002 SHALL have parameter LOCK_COUNT, default 8, meaning the number of consecutive control tokens at one offset needed to declare lock.
REQ-003 SHALL have parameter SEARCH_TIMEOUT, default 2048, meaning the number of clocks without a qualifying control run before the offset advances or lock is lost.
REQ-004 SHALL have port clk_pixel, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port raw_symbol, input, 10 bits: one deserialized word per clock, bit 0 earliest on the wire, arbitrary bit rotation.
REQ-007 SHALL have port locked, output, 1 bit: word alignment established.
REQ-008 SHALL have port offset, output, 4 bits: current alignment offset, 0..9.
REQ-009 SHALL have port video_data, output, 8 bits: TMDS video decode of the aligned symbol.
REQ-010 SHALL have port control_data, output, 2 bits, and port is_control, output, 1 bit: control-token decode and its match flag.
REQ-011 SHALL have port terc4_data, output, 4 bits, and port is_terc4, output, 1 bit: TERC4 decode and its match flag.
REQ-012 SHALL have port is_guard, output, 1 bit: the aligned symbol equals this channel's video guard band.

Function
REQ-013 SHALL form window = {raw_symbol, raw_prev} (20 bits), where raw_prev is raw_symbol registered one clock earlier; aligned = window[offset+9 : offset].
REQ-014 SHALL register all decode outputs; a symbol whose last bit arrives in raw_symbol at edge n appears on the outputs after edge n+1.
REQ-015 SHALL decode video as follows: d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-016 SHALL match control tokens 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11; on no match, is_control=0 and control_data holds 00.
REQ-017 SHALL match the 16-entry TERC4 table of HDMI 1.4 (e.g. 1010011100->0, 1011000011->F); on no match, is_terc4=0 and terc4_data holds 0.
REQ-018 SHALL match the guard band 1011001100 for CHANNEL 0 or 2, and 0100110011 for CHANNEL 1.
REQ-019 SHALL always compute video_data, regardless of the match flags; period selection belongs downstream.
REQ-020 SHALL implement FSM SEARCH/LOCKED with a run counter (consecutive control tokens) and a timer (clocks since the last qualifying run).
REQ-021 In SEARCH: a control token increments run; a non-control symbol clears run; run reaching LOCK_COUNT -> LOCKED, with timer cleared, same cycle the Nth token is decoded.
REQ-022 In SEARCH: timer reaching SEARCH_TIMEOUT -> offset = (offset+1) mod 10 (9 wraps to 0), run and timer cleared.
REQ-023 In LOCKED: each completed run of LOCK_COUNT clears timer; timer reaching SEARCH_TIMEOUT -> SEARCH, locked=0, offset+1 mod 10, run and timer cleared.
REQ-024 SHALL keep offset unchanged while LOCKED.
REQ-025 On a simultaneous run completion and timer expiry, run completion SHALL win.
REQ-026 SHALL saturate counters; no wrap-around is allowed.

Reset
REQ-027 While RST=0, SHALL hold state SEARCH, offset 0, run/timer/raw_prev 0, and all outputs 0, immediately and asynchronously.
REQ-028 Reset deassertion mid-stream SHALL restart the search at offset 0; no output may glitch high before the first registered decode.

Verification
REQ-029 RST=0 for 3 clocks mid-lock -> locked=0, offset=0, all outputs 0 during reset.
REQ-030 Aligned stream of 10'h354 x8 -> locked=1 two clocks after the 8th word, is_control=1, control_data=00, offset=0.
REQ-031 SEARCH_TIMEOUT=64, continuous 10'h354 rotated by 3 bits -> offset steps 0,1,2 every 64 clocks, then locked with offset=3, control_data=00.
REQ-032 Locked, feed 10'h100 then 10'h0FF -> video_data 00 then FF; is_control=0.
REQ-033 Locked, CHANNEL=0, feed 10'h29C, 10'h2C3, 10'h2CC -> terc4_data 0 then F with is_terc4=1; then is_guard=1.
REQ-034 Locked, SEARCH_TIMEOUT=64, 64 consecutive non-control symbols -> locked=0, offset incremented by 1; a run at offset 9 timing out -> offset 0.
